// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for a shared fifo with bounded bursts.
// Optional statistics counters enabled by defining ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_wr_data,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  input  logic                   stat_clr,
  output logic [N_REQ*16-1:0]    stat_beats,
  output logic [15:0]            stat_stall
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    beat_d       = beat_q;
    found        = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // search starts just after the last winner
        for (int k = 1; k <= N_REQ; k++) begin
          if (!found && req_valid[(int'(last_q) + k) % N_REQ]) begin
            found   = 1'b1;
            grant_d = ID_W'((int'(last_q) + k) % N_REQ);
          end
        end
        if (found) begin
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy                = 1'b1;
        req_ready[grant_q]  = !fifo_full;
        fifo_wr_en          = req_valid[grant_q] & !fifo_full;
        fifo_wr_data        = req_data[int'(grant_q)*WIDTH +: WIDTH];
        if (!req_valid[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else if (fifo_wr_en) begin
          if (beat_q == CNT_W'(MAX_BURST - 1)) begin
            last_d  = grant_q;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_q;

`ifdef ARB_STATS_EN
  logic [15:0] beats_q [N_REQ];
  logic [15:0] beats_d [N_REQ];
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    for (int i = 0; i < N_REQ; i++) begin
      beats_d[i] = beats_q[i];
      if (stat_clr)
        beats_d[i] = '0;
      else if (fifo_wr_en && grant_q == ID_W'(i) && beats_q[i] != 16'hFFFF)
        beats_d[i] = beats_q[i] + 16'd1;
    end
    if (stat_clr)
      stall_d = '0;
    else if (busy && req_valid[grant_q] && fifo_full && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      for (int i = 0; i < N_REQ; i++) beats_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      for (int i = 0; i < N_REQ; i++) beats_q[i] <= beats_d[i];
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < N_REQ; i++) stat_beats[i*16 +: 16] = beats_q[i];
  end

  assign stat_stall = stall_q;
`else
  logic stat_clr_unused;

  assign stat_clr_unused = stat_clr;
  assign stat_beats      = '0;
  assign stat_stall      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, rotation, back-pressure,
// early release, async reset and (with ARB_STATS_EN) statistics.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wr_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic           stat_clr;
  logic [N*16-1:0] stat_beats;
  logic [15:0]    stat_stall;

  int total = 0;
  int bad   = 0;

  int rem  [N];
  int sent [N];
  int base [N];
  int wd [$];
  int wg [$];
  logic [31:0] wtr;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy),
    .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rem[i] != 0);
      req_data[i*W +: W] = W'(base[i] + sent[i]);
    end
  endtask

  task automatic cyc();
    logic [N-1:0] acc;
    #2;
    acc = req_valid & req_ready;
    wtr = {wtr[30:0], fifo_wr_en};
    if (fifo_wr_en) begin
      wd.push_back(int'(fifo_wr_data));
      wg.push_back(int'(grant_id));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        rem[i]--;
        sent[i]++;
      end
    drive();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_full = 1'b0;
    stat_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; sent[i] = 0; base[i] = 0;
    end
    drive();
    wd.delete();
    wg.delete();
    wtr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({busy, fifo_wr_en, req_ready, grant_id, fifo_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h want=0",
               {busy, fifo_wr_en, req_ready, grant_id, fifo_wr_data});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    test_reset();
    base[0] = 1;
    rem[0] = 8;
    drive();
    for (int c = 0; c < 11; c++) cyc();
    total++;
    if (wtr[10:0] !== 11'b01111011110) begin
      bad++;
      $display("FAIL single_trace got=%b want=01111011110", wtr[10:0]);
    end
    total++;
    if (wd.size() != 8 || wd[0] != 1 || wd[3] != 4 || wd[4] != 5 || wd[7] != 8) begin
      bad++;
      $display("FAIL single_data got_n=%0d want_n=8", wd.size());
    end
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_end got=%b want=0", busy);
    end
  endtask

  task automatic test_round_robin();
    int e;
    int nbad;
    int kk [N];
    test_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 5; base[i] = 16'h100 * (i + 1); kk[i] = 0;
    end
    drive();
    for (int c = 0; c < 40; c++) cyc();
    total++;
    if (wd.size() != 20) begin
      bad++;
      $display("FAIL rr_count got=%0d want=20", wd.size());
    end
    nbad = 0;
    for (int n = 0; n < 17 && n < wd.size(); n++) begin
      e = (n == 16) ? 0 : n / 4;
      if (wg[n] != e || wd[n] != base[e] + kk[e]) nbad++;
      kk[e]++;
    end
    total++;
    if (nbad != 0 || wd.size() < 17) begin
      bad++;
      $display("FAIL rr_order got_bad=%0d want=0", nbad);
    end
  endtask

  task automatic test_full_stall();
    test_reset();
    base[2] = 16'h200;
    rem[2] = 6;
    drive();
    for (int c = 0; c < 12; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      #1;
      if (fifo_full) begin
        total++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
          bad++;
          $display("FAIL full_hold got=%b%b%h want=0_0_0", fifo_wr_en, busy, req_ready);
        end
      end
      cyc();
    end
    fifo_full = 1'b0;
    total++;
    if (wtr[11:0] !== 12'b011000110110) begin
      bad++;
      $display("FAIL full_trace got=%b want=011000110110", wtr[11:0]);
    end
    total++;
    if (wd.size() != 6 || wd[2] != 16'h202 || wd[3] != 16'h203 || wd[5] != 16'h205) begin
      bad++;
      $display("FAIL full_data got_n=%0d want_n=6", wd.size());
    end
`ifdef ARB_STATS_EN
    #1;
    total++;
    if (stat_beats !== {16'd0, 16'd6, 16'd0, 16'd0} || stat_stall !== 16'd3) begin
      bad++;
      $display("FAIL stats got=%h/%h want=0000000600000000/3", stat_beats, stat_stall);
    end
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    #1;
    total++;
    if (stat_beats !== '0 || stat_stall !== '0) begin
      bad++;
      $display("FAIL stats_clr got=%h/%h want=0/0", stat_beats, stat_stall);
    end
`else
    #1;
    total++;
    if (stat_beats !== '0 || stat_stall !== '0) begin
      bad++;
      $display("FAIL stats_tied got=%h/%h want=0/0", stat_beats, stat_stall);
    end
`endif
  endtask

  task automatic test_early_release();
    test_reset();
    base[1] = 16'h10; rem[1] = 2;
    base[3] = 16'h30; rem[3] = 3;
    drive();
    cyc(); cyc(); cyc();
    #1;
    total++;
    if (busy !== 1'b1 || fifo_wr_en !== 1'b0 || grant_id !== 2'd1) begin
      bad++;
      $display("FAIL drop_grant got=%b%b%0d want=1_0_1", busy, fifo_wr_en, grant_id);
    end
    cyc();
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle got=%b want=0", busy);
    end
    cyc();
    #1;
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || fifo_wr_en !== 1'b1 || fifo_wr_data !== 16'h30) begin
      bad++;
      $display("FAIL drop_next got=%b_%0d_%h want=1_3_0030", busy, grant_id, fifo_wr_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    test_reset();
    base[0] = 16'h50; rem[0] = 8;
    drive();
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, fifo_wr_en, req_ready, fifo_wr_data} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {busy, fifo_wr_en, req_ready, fifo_wr_data});
    end
    cyc(); cyc();
    total++;
    if (wd.size() != 2) begin
      bad++;
      $display("FAIL reset_no_write got=%0d want=2", wd.size());
    end
    rst_n = 1'b1;
    base[3] = 16'h70; rem[3] = 2;
    drive();
    cyc(); cyc(); cyc();
    total++;
    if (wg.size() < 3 || wg[2] != 0 || wd[2] != 16'h52) begin
      bad++;
      $display("FAIL reset_regrant got_n=%0d want id0 data 52", wg.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    stat_clr = 1'b0;
    wtr = '0;
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
